mux_arbiter: RTL and testbench
==============================

MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: width of each channel data bus.
REQ-002 SHALL have parameter CHANNELS, default 4: number of input channels, legal range 2..16.
REQ-003 SHALL have parameter MODE, default 1: 0 = fixed priority (lowest index wins), 1 = round-robin.
REQ-004 SHALL have port i_clock, input, 1: the single clock; all state updates on the rising edge.
REQ-005 SHALL have port i_reset, input, 1: reset, synchronous and active-low.
REQ-006 SHALL have port i_data, input, CHANNELS*DATA_WIDTH: channel k data occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-007 SHALL have port i_valid, input, CHANNELS: per-channel data-valid.
REQ-008 SHALL have port o_ready, output, CHANNELS: per-channel accept strobe.
REQ-009 SHALL have port o_data, output, DATA_WIDTH: registered selected data.
REQ-010 SHALL have port o_channel, output, clog2(CHANNELS): index of the channel that supplied o_data.
REQ-011 SHALL have port o_valid, output, 1: o_data/o_channel hold an unconsumed word.
REQ-012 SHALL have port i_ready, input, 1: downstream accepts the word this cycle.

Function
REQ-013 SHALL define load = !o_valid || i_ready; the output register SHALL accept a new word only when load is 1.
REQ-014 SHALL assert at most one o_ready bit per cycle: o_ready[k] = grant[k] && load.
REQ-015 SHALL compute grant combinationally from i_valid and the priority pointer; o_ready never depends on i_data.
REQ-016 In MODE 0, grant SHALL go to the lowest-index channel with i_valid = 1.
REQ-017 In MODE 1, grant SHALL go to the first valid channel at or after the pointer, searching upward with wrap from CHANNELS-1 to 0.
REQ-018 A transfer on channel k SHALL occur when i_valid[k] && o_ready[k].
REQ-019 On a transfer, the next edge SHALL load o_data = channel k data and o_channel = k, and SHALL set o_valid = 1; latency is exactly 1 cycle.
REQ-020 In MODE 1, a transfer on k SHALL set the pointer to k+1, or to 0 when k = CHANNELS-1; with no transfer the pointer SHALL hold.
REQ-021 With no transfer and i_ready = 1, o_valid SHALL clear at the next edge; o_data and o_channel SHALL hold their last values.
REQ-022 With o_valid = 1 and i_ready = 0, o_data, o_channel and o_valid SHALL hold, and all o_ready bits SHALL be 0 (backpressure).
REQ-023 When o_valid = 1, i_ready = 1 and a transfer occur in the same cycle, the word SHALL be replaced without a bubble, giving full throughput of 1 word/cycle.
REQ-024 Deasserting i_valid[k] without a transfer SHALL be legal and SHALL leave all state unchanged.

Reset
REQ-025 While i_reset = 0 at a rising edge, o_valid SHALL be 0, o_data SHALL be 0, o_channel SHALL be 0 and the pointer SHALL be 0.
REQ-026 During reset, o_ready SHALL be all 0.
REQ-027 A reset asserted mid-operation SHALL discard any held word; no transfer SHALL be counted in that cycle.
REQ-028 The first edge after reset release SHALL behave as an empty output register (load = 1).

Structure
REQ-029 MODE encodings (MODE_FIXED = 0, MODE_RR = 1) SHALL live in the shared constants package/include.
REQ-030 Grant logic SHALL be one sub-module, arbiter_rr (inputs: request vector, pointer, mode; output: one-hot grant and index).
REQ-031 The data path SHALL be an indexed select feeding a single output register stage, with no additional storage.

Verification
REQ-032 Reset: drive i_reset = 0 for 2 cycles with all i_valid = 1 -> o_valid = 0, o_data = 0, o_channel = 0, o_ready = 0000.
REQ-033 RR fairness (CHANNELS = 4, MODE 1): i_valid = 1111 held, i_ready = 1 -> o_channel sequence 0,1,2,3,0, one word per cycle.
REQ-034 Fixed priority (MODE 0): i_valid = 1010 held -> o_channel stays 1 every cycle; channel 3 is never granted.
REQ-035 Backpressure: hold i_ready = 0 with o_valid = 1 and data 0xA5A5 for 3 cycles -> o_data = 0xA5A5 stable and o_ready = 0000; release -> next word appears 1 cycle later.
REQ-036 Wrap and sparse requests: pointer = 3, i_valid = 0011 -> grant channel 0, pointer becomes 1.
REQ-037 Mid-operation reset: reset while o_valid = 1 -> o_valid = 0 next cycle, and after release arbitration restarts from channel 0.

Source files
------------

// File: rtl/mux_arbiter_pkg.sv
// Shared constants and helpers for the mux_arbiter slice.
package mux_arbiter_pkg;

  // Arbitration mode encodings used for the MODE parameter.
  localparam int unsigned MODE_FIXED = 32'd0;
  localparam int unsigned MODE_RR    = 32'd1;

  // Round-robin pointer advance: the slot after idx, wrapping to 0 past the last channel.
  function automatic int unsigned next_ptr(input int unsigned idx, input int unsigned channels);
    if (idx >= channels - 32'd1) begin
      return 32'd0;
    end else begin
      return idx + 32'd1;
    end
  endfunction

endpackage

// File: rtl/arbiter_rr.sv
// Combinational grant logic: first requester at or after a start slot, with wrap.
// In fixed mode the search always starts at slot 0, which gives lowest-index priority.
module arbiter_rr
  import mux_arbiter_pkg::*;
#(
  parameter int CHANNELS = 4
) (
  input  logic [CHANNELS-1:0]         req,
  input  logic [$clog2(CHANNELS)-1:0] ptr,
  input  logic                        mode_rr,
  output logic [CHANNELS-1:0]         grant,
  output logic [$clog2(CHANNELS)-1:0] idx
);

  localparam int PW = $clog2(CHANNELS);

  logic [PW-1:0] start_s;
  logic          found_s;
  int            cand_s;

  // Scan CHANNELS slots upward from the start slot and keep the first requester.
  always_comb begin
    grant   = '0;
    idx     = '0;
    found_s = 1'b0;
    cand_s  = 0;
    if (mode_rr) begin
      start_s = ptr;
    end else begin
      start_s = '0;
    end
    for (int i = 0; i < CHANNELS; i++) begin
      cand_s = (int'(start_s) + i) % CHANNELS;
      if (!found_s && req[cand_s]) begin
        found_s       = 1'b1;
        grant[cand_s] = 1'b1;
        idx           = PW'(cand_s);
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/mux_arbiter.sv
// N-channel valid/ready arbiter feeding a single registered output word.
// Grant depends only on i_valid and the round-robin pointer; data is an indexed select.
module mux_arbiter
  import mux_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int CHANNELS   = 4,
  parameter int MODE       = 1
) (
  input  logic                           i_clock,
  input  logic                           i_reset,
  input  logic [CHANNELS*DATA_WIDTH-1:0] i_data,
  input  logic [CHANNELS-1:0]            i_valid,
  output logic [CHANNELS-1:0]            o_ready,
  output logic [DATA_WIDTH-1:0]          o_data,
  output logic [$clog2(CHANNELS)-1:0]    o_channel,
  output logic                           o_valid,
  input  logic                           i_ready
);

  localparam int   PW       = $clog2(CHANNELS);
  localparam logic MODE_BIT = (MODE == int'(MODE_RR)) ? 1'b1 : 1'b0;

  logic [PW-1:0]         ptr_r;
  logic [CHANNELS-1:0]   grant_s;
  logic [PW-1:0]         idx_s;
  logic                  load_s;
  logic                  xfer_s;
  logic [DATA_WIDTH-1:0] sel_data_s;

  arbiter_rr #(
    .CHANNELS (CHANNELS)
  ) u_arbiter_rr (
    .req     (i_valid),
    .ptr     (ptr_r),
    .mode_rr (MODE_BIT),
    .grant   (grant_s),
    .idx     (idx_s)
  );

  // Accept strobes: granted channel only, only when the output register can load, never in reset.
  always_comb begin
    load_s     = !o_valid || i_ready;
    sel_data_s = i_data[idx_s*DATA_WIDTH +: DATA_WIDTH];
    if (i_reset) begin
      o_ready = grant_s & {CHANNELS{load_s}};
    end else begin
      o_ready = '0;
    end
    xfer_s = |(i_valid & o_ready);
  end

  // Output word register and round-robin pointer; a reset discards any held word.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      o_valid   <= 1'b0;
      o_data    <= '0;
      o_channel <= '0;
      ptr_r     <= '0;
    end else begin
      if (xfer_s) begin
        o_valid   <= 1'b1;
        o_data    <= sel_data_s;
        o_channel <= idx_s;
        if (MODE_BIT) begin
          ptr_r <= PW'(next_ptr(32'(idx_s), 32'(CHANNELS)));
        end else begin
          ptr_r <= ptr_r;
        end
      end else if (i_ready) begin
        o_valid <= 1'b0;
      end else begin
        o_valid <= o_valid;
      end
    end
  end

endmodule

// File: tb/tb_mux_arbiter.sv
// Directed bench: one round-robin and one fixed-priority instance share the same stimulus.
module tb_mux_arbiter;
  import mux_arbiter_pkg::*;

  localparam int DW = 16;
  localparam int CH = 4;

  logic           clk;
  logic           i_reset;
  logic [CH*DW-1:0] i_data;
  logic [CH-1:0]  i_valid;
  logic           i_ready;

  logic [CH-1:0]  rr_ready, fp_ready;
  logic [DW-1:0]  rr_data, fp_data;
  logic [1:0]     rr_chan, fp_chan;
  logic           rr_valid, fp_valid;

  int n_checks = 0;
  int n_fail   = 0;

  mux_arbiter #(.DATA_WIDTH(DW), .CHANNELS(CH), .MODE(int'(MODE_RR))) dut_rr (
    .i_clock(clk), .i_reset(i_reset), .i_data(i_data), .i_valid(i_valid),
    .o_ready(rr_ready), .o_data(rr_data), .o_channel(rr_chan), .o_valid(rr_valid),
    .i_ready(i_ready)
  );

  mux_arbiter #(.DATA_WIDTH(DW), .CHANNELS(CH), .MODE(int'(MODE_FIXED))) dut_fp (
    .i_clock(clk), .i_reset(i_reset), .i_data(i_data), .i_valid(i_valid),
    .o_ready(fp_ready), .o_data(fp_data), .o_channel(fp_chan), .o_valid(fp_valid),
    .i_ready(i_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int k, input logic [DW-1:0] v);
    i_data[k*DW +: DW] = v;
  endtask

  initial begin
    logic [1:0]    rr_seq [5];
    logic [DW-1:0] dat    [4];
    logic [1:0]    rr_seq2 [3];
    rr_seq  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    rr_seq2 = '{2'd1, 2'd3, 2'd1};
    dat     = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

    for (int k = 0; k < CH; k++) set_ch(k, dat[k]);
    i_reset = 1'b0;
    i_valid = 4'b1111;
    i_ready = 1'b1;

    // Reset with every channel requesting.
    tick(); tick();
    check("rst_valid", 32'(rr_valid), 32'd0);
    check("rst_data", 32'(rr_data), 32'd0);
    check("rst_chan", 32'(rr_chan), 32'd0);
    check("rst_ready_rr", 32'(rr_ready), 32'h0);
    check("rst_ready_fp", 32'(fp_ready), 32'h0);
    check("rst_valid_fp", 32'(fp_valid), 32'd0);

    // Release: first edge behaves as an empty register; round-robin 0,1,2,3,0.
    i_reset = 1'b1;
    #1;
    check("rel_ready_rr", 32'(rr_ready), 32'h1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("rr_chan%0d", i), 32'(rr_chan), 32'(rr_seq[i]));
      check($sformatf("rr_data%0d", i), 32'(rr_data), 32'(dat[rr_seq[i]]));
      check($sformatf("rr_valid%0d", i), 32'(rr_valid), 32'd1);
      check($sformatf("fp_chan_all%0d", i), 32'(fp_chan), 32'd0);
    end

    // Sparse requests 1010: fixed stays on 1; round-robin from pointer 1 gives 1,3,1.
    i_valid = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("fp_chan1010_%0d", i), 32'(fp_chan), 32'd1);
      check($sformatf("rr_chan1010_%0d", i), 32'(rr_chan), 32'(rr_seq2[i]));
    end

    // No requests with i_ready high: valid clears, word holds.
    i_valid = 4'b0000;
    tick();
    check("idle_valid", 32'(rr_valid), 32'd0);
    check("idle_data", 32'(rr_data), 32'h2222);
    check("idle_chan", 32'(rr_chan), 32'd1);

    // Load 0xA5A5 from channel 2 (round-robin pointer becomes 3), then backpressure.
    set_ch(2, 16'hA5A5);
    i_valid = 4'b0100;
    tick();
    check("bp_load_data", 32'(rr_data), 32'hA5A5);
    check("bp_load_chan", 32'(fp_chan), 32'd2);
    i_ready = 1'b0;
    i_valid = 4'b1111;
    #1;
    check("bp_ready_rr", 32'(rr_ready), 32'h0);
    check("bp_ready_fp", 32'(fp_ready), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("bp_data%0d", i), 32'(rr_data), 32'hA5A5);
      check($sformatf("bp_valid%0d", i), 32'(rr_valid), 32'd1);
      check($sformatf("bp_ready%0d", i), 32'(rr_ready), 32'h0);
    end

    // Release with requests 0011 at pointer 3: wrap grants channel 0, pointer moves to 1.
    set_ch(0, 16'h0B0B);
    i_ready = 1'b1;
    i_valid = 4'b0011;
    #1;
    check("wrap_ready_rr", 32'(rr_ready), 32'h1);
    tick();
    check("wrap_data", 32'(rr_data), 32'h0B0B);
    check("wrap_chan", 32'(rr_chan), 32'd0);
    check("ptr1_ready_rr", 32'(rr_ready), 32'h2);
    check("ptr1_ready_fp", 32'(fp_ready), 32'h1);
    tick();
    check("ptr1_chan_rr", 32'(rr_chan), 32'd1);
    check("ptr1_chan_fp", 32'(fp_chan), 32'd0);

    // Mid-operation reset discards the held word and restarts round-robin at 0.
    i_valid = 4'b1111;
    i_reset = 1'b0;
    #1;
    check("mid_rst_ready", 32'(rr_ready), 32'h0);
    tick();
    check("mid_rst_valid", 32'(rr_valid), 32'd0);
    check("mid_rst_data", 32'(rr_data), 32'd0);
    i_reset = 1'b1;
    #1;
    check("restart_ready", 32'(rr_ready), 32'h1);
    tick();
    check("restart_chan", 32'(rr_chan), 32'd0);
    check("restart_valid", 32'(rr_valid), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
